// File: rtl/bp_upd_pkg.sv
// rtl/bp_upd_pkg.sv - shared update record and widths for the branch-predictor update arbiter
package bp_upd_pkg;

  localparam int BP_PC_W = 64;

  typedef struct packed {
    logic               cond;
    logic               taken;
    logic [BP_PC_W-1:0] pc;
    logic [BP_PC_W-1:0] target;
  } bp_upd_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// rtl/bp_upd_fifo.sv - circular buffer with NUM_WR contiguous write ports from tail and a single pop
module bp_upd_fifo
  import bp_upd_pkg::*;
#(
  parameter int NUM_WR = 2,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [$clog2(DEPTH):0] i_push_cnt,
  input  bp_upd_t [NUM_WR-1:0]   i_push_data,
  input  logic                   i_pop,
  output bp_upd_t                o_head_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  bp_upd_t       r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // Port j lands at tail+j; DEPTH is a power of two so pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_WR; j++) begin
      if (CW'(j) < i_push_cnt) begin
        r_mem[r_tail + AW'(j)] <= i_push_data[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + AW'(i_push_cnt);
      r_count <= r_count + i_push_cnt - CW'(i_pop);
      if (i_pop) begin
        r_head <= r_head + AW'(1);
      end
    end
  end

  assign o_head_data = r_mem[r_head];
  assign o_count     = r_count;

endmodule

// File: rtl/bp_update_arbiter.sv
// rtl/bp_update_arbiter.sv - round-robin merge of branch-unit updates onto the predictor port; optional BP_UPD_BYPASS_EN
module bp_update_arbiter
  import bp_upd_pkg::*;
#(
  parameter int NUM_BR_FU = 2,
  parameter int DEPTH     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_BR_FU-1:0]                fu_br_done_i,
  input  logic [NUM_BR_FU-1:0]                fu_br_cond_i,
  input  logic [NUM_BR_FU-1:0]                fu_br_taken_i,
  input  logic [NUM_BR_FU-1:0][BP_PC_W-1:0]   fu_br_PC_i,
  input  logic [NUM_BR_FU-1:0][BP_PC_W-1:0]   fu_br_target_i,
  output logic [NUM_BR_FU-1:0]                fu_br_rdy_o,
  input  logic                                bp_upd_rdy_i,
  output logic                                bp_br_done_o,
  output logic                                bp_br_cond_o,
  output logic                                bp_br_taken_o,
  output logic [BP_PC_W-1:0]                  bp_br_PC_o,
  output logic [BP_PC_W-1:0]                  bp_br_target_o,
  output logic [$clog2(DEPTH):0]              occ_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(NUM_BR_FU);

  logic [RW-1:0]              r_rr_ptr;
  logic [CW-1:0]              w_count;
  logic [CW:0]                w_free;
  logic [CW-1:0]              w_n_grant;
  logic [CW-1:0]              w_push_cnt;
  logic [RW:0]                w_sum;
  logic [RW-1:0]              w_idx;
  logic [RW-1:0]              w_last;
  logic                       w_bypass;
  logic                       w_pop;
  bp_upd_t                    w_head;
  bp_upd_t                    w_out;
  bp_upd_t [NUM_BR_FU-1:0]    w_req;
  bp_upd_t [NUM_BR_FU-1:0]    w_push_data;

  // Capacity comes from the registered count only, keeping bp_upd_rdy_i off the grant path.
  always_comb begin
    w_free = (CW+1)'(DEPTH) - {1'b0, w_count};
`ifdef BP_UPD_BYPASS_EN
    if (w_count == '0 && bp_upd_rdy_i) begin
      w_free = (CW+1)'(DEPTH + 1);
    end
`endif
    fu_br_rdy_o = '0;
    w_req       = '0;
    w_n_grant   = '0;
    w_last      = '0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < NUM_BR_FU; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (RW+1)'(k);
      if (w_sum >= (RW+1)'(NUM_BR_FU)) begin
        w_sum = w_sum - (RW+1)'(NUM_BR_FU);
      end
      w_idx = w_sum[RW-1:0];
      if (!rst && fu_br_done_i[w_idx] && ({1'b0, w_n_grant} < w_free)) begin
        fu_br_rdy_o[w_idx]        = 1'b1;
        w_req[w_n_grant[RW-1:0]] = '{cond:   fu_br_cond_i[w_idx],
                                     taken:  fu_br_taken_i[w_idx],
                                     pc:     fu_br_PC_i[w_idx],
                                     target: fu_br_target_i[w_idx]};
        w_last    = w_idx;
        w_n_grant = w_n_grant + CW'(1);
      end
    end
  end

  always_comb begin
    w_bypass    = 1'b0;
    w_push_cnt  = w_n_grant;
    w_push_data = w_req;
`ifdef BP_UPD_BYPASS_EN
    // The first granted update goes straight out; the rest shift down one write port.
    if (w_count == '0 && bp_upd_rdy_i && w_n_grant != '0) begin
      w_bypass   = 1'b1;
      w_push_cnt = w_n_grant - CW'(1);
      for (int j = 0; j < NUM_BR_FU - 1; j++) begin
        w_push_data[j] = w_req[j+1];
      end
    end
`endif
  end

  assign w_pop = (w_count != '0) && bp_upd_rdy_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (|fu_br_rdy_o) begin
      r_rr_ptr <= (w_last == RW'(NUM_BR_FU - 1)) ? '0 : w_last + RW'(1);
    end
  end

  bp_upd_fifo #(
    .NUM_WR (NUM_BR_FU),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push_cnt  (w_push_cnt),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_count     (w_count)
  );

  always_comb begin
    bp_br_done_o = 1'b0;
    w_out        = '0;
    if (w_count != '0) begin
      bp_br_done_o = 1'b1;
      w_out        = w_head;
    end else if (w_bypass) begin
      bp_br_done_o = 1'b1;
      w_out        = w_req[0];
    end
  end

  assign bp_br_cond_o   = w_out.cond;
  assign bp_br_taken_o  = w_out.taken;
  assign bp_br_PC_o     = w_out.pc;
  assign bp_br_target_o = w_out.target;
  assign occ_o          = w_count;

endmodule

// File: tb/tb_bp_update_arbiter.sv
// tb/tb_bp_update_arbiter.sv - vector table and ordered scoreboard bench for bp_update_arbiter; BP_UPD_BYPASS_EN selects the bypass sequence
module tb_bp_update_arbiter;
  import bp_upd_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       done, cond, taken, rdy_o;
  logic [1:0][63:0] pc, tgt;
  logic             upd_rdy;
  logic             bd, bc, bt;
  logic [63:0]      bpc, btg;
  logic [3:0]       occ;

  always #5 clk = ~clk;

  bp_update_arbiter #(.NUM_BR_FU(2), .DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .fu_br_done_i   (done),
    .fu_br_cond_i   (cond),
    .fu_br_taken_i  (taken),
    .fu_br_PC_i     (pc),
    .fu_br_target_i (tgt),
    .fu_br_rdy_o    (rdy_o),
    .bp_upd_rdy_i   (upd_rdy),
    .bp_br_done_o   (bd),
    .bp_br_cond_o   (bc),
    .bp_br_taken_o  (bt),
    .bp_br_PC_o     (bpc),
    .bp_br_target_o (btg),
    .occ_o          (occ)
  );

  typedef struct {
    logic [1:0]  done;
    logic        rdy;
    logic [1:0]  grant;
    logic        swap;
    logic [3:0]  occ;
    logic        bd;
    logic [63:0] p0;
    logic [63:0] p1;
  } vec_t;

  vec_t    tbl[$];
  bp_upd_t sbq[$];
  int      n_chk = 0;
  int      n_bad = 0;

  function automatic bp_upd_t mk_upd(input logic [63:0] p);
    bp_upd_t e;
    e.cond   = p[8] ^ p[12];
    e.taken  = p[9] ^ p[8];
    e.pc     = p;
    e.target = p + 64'h80;
    return e;
  endfunction

  function automatic vec_t V(input int d, input int r, input int g, input int s,
                             input int o, input int b, input int p0, input int p1);
    vec_t v;
    v.done = 2'(d); v.rdy = 1'(r); v.grant = 2'(g); v.swap = 1'(s);
    v.occ = 4'(o); v.bd = 1'(b); v.p0 = 64'(p0); v.p1 = 64'(p1);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [129:0] act, input logic [129:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] d, input logic [63:0] p0, input logic [63:0] p1);
    bp_upd_t e0, e1;
    e0 = mk_upd(p0);
    e1 = mk_upd(p1);
    done   = d;
    pc[0]  = p0;       pc[1]  = p1;
    tgt[0] = e0.target; tgt[1] = e1.target;
    cond   = {e1.cond, e0.cond};
    taken  = {e1.taken, e0.taken};
  endtask

  task automatic apply(input vec_t v, input string tag);
    int u;
    drive(v.done, v.p0, v.p1);
    upd_rdy = v.rdy;
    for (int k = 0; k < 2; k++) begin
      u = v.swap ? 1 - k : k;
      if (v.grant[u]) sbq.push_back(mk_upd(u == 1 ? v.p1 : v.p0));
    end
    @(negedge clk);
    chk({tag, ".grant"}, 130'(rdy_o), 130'(v.grant));
    chk({tag, ".occ"},   130'(occ),   130'(v.occ));
    chk({tag, ".done"},  130'(bd),    130'(v.bd));
    if (bd) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL %s.sb: update %h out with nothing expected", tag, bpc);
      end else begin
        chk({tag, ".data"}, {bc, bt, bpc, btg}, sbq[0]);
        if (upd_rdy) void'(sbq.pop_front());
      end
    end else begin
      chk({tag, ".idle_pc"}, 130'(bpc), 130'(0));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    upd_rdy = 1'b1;
    drive(2'b11, 64'h10, 64'h20);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.grant", 130'(rdy_o), 130'(0));
    chk("rst.done",  130'(bd),    130'(0));
    chk("rst.occ",   130'(occ),   130'(0));
    chk("rst.pc",    130'(bpc),   130'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifndef BP_UPD_BYPASS_EN
    tbl.push_back(V(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 1, 1, 0, 0, 0, 'h100, 0));
    tbl.push_back(V(0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(2, 1, 2, 0, 0, 0, 0, 'h150));
    tbl.push_back(V(3, 1, 3, 0, 1, 1, 'h200, 'h300));
    tbl.push_back(V(0, 1, 0, 0, 2, 1, 0, 0));
    tbl.push_back(V(0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(3, 0, 3, 0, 0, 0, 'h1000, 'h1100));
    tbl.push_back(V(3, 0, 3, 0, 2, 1, 'h1200, 'h1300));
    tbl.push_back(V(3, 0, 3, 0, 4, 1, 'h1400, 'h1500));
    tbl.push_back(V(1, 0, 1, 0, 6, 1, 'h1600, 0));
    tbl.push_back(V(1, 0, 1, 0, 7, 1, 'h1700, 0));
    tbl.push_back(V(3, 0, 0, 0, 8, 1, 'h1800, 'h1900));
    tbl.push_back(V(3, 1, 0, 0, 8, 1, 'h1800, 'h1900));
    tbl.push_back(V(3, 1, 2, 0, 7, 1, 'h1800, 'h1900));
    tbl.push_back(V(1, 1, 1, 0, 7, 1, 'h1800, 0));
    tbl.push_back(V(0, 1, 0, 0, 7, 1, 0, 0));
    tbl.push_back(V(0, 1, 0, 0, 6, 1, 0, 0));
    tbl.push_back(V(0, 1, 0, 0, 5, 1, 0, 0));
    tbl.push_back(V(1, 1, 1, 0, 4, 1, 'h2000, 0));
    tbl.push_back(V(2, 1, 2, 0, 4, 1, 0, 'h2100));
    tbl.push_back(V(1, 1, 1, 0, 4, 1, 'h2200, 0));
    tbl.push_back(V(0, 1, 0, 0, 4, 1, 0, 0));
    tbl.push_back(V(0, 1, 0, 0, 3, 1, 0, 0));
    tbl.push_back(V(0, 1, 0, 0, 2, 1, 0, 0));
    tbl.push_back(V(0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(3, 1, 3, 1, 0, 0, 'h3000, 'h3100));
    tbl.push_back(V(0, 1, 0, 0, 2, 1, 0, 0));
    tbl.push_back(V(0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

    apply(V(3, 0, 3, 1, 0, 0, 'h4000, 'h4100), "r1");
    apply(V(3, 0, 3, 1, 2, 1, 'h4200, 'h4300), "r2");
    apply(V(1, 0, 1, 0, 4, 1, 'h4400, 0), "r3");
    rst     = 1'b1;
    upd_rdy = 1'b0;
    drive(2'b11, 64'h4500, 64'h4600);
    @(negedge clk);
    chk("rst_mid.grant", 130'(rdy_o), 130'(0));
    chk("rst_mid.occ",   130'(occ),   130'(5));
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    apply(V(3, 1, 3, 0, 0, 0, 'h5000, 'h5100), "r4");
    apply(V(0, 1, 0, 0, 2, 1, 0, 0), "r5");
    apply(V(0, 1, 0, 0, 1, 1, 0, 0), "r6");
    apply(V(0, 1, 0, 0, 0, 0, 0, 0), "r7");
`else
    apply(V(1, 1, 1, 0, 0, 1, 'h400, 0), "b1");
    apply(V(0, 1, 0, 0, 0, 0, 0, 0), "b2");
    apply(V(3, 1, 3, 1, 0, 1, 'h500, 'h600), "b3");
    apply(V(0, 1, 0, 0, 1, 1, 0, 0), "b4");
    apply(V(0, 1, 0, 0, 0, 0, 0, 0), "b5");
    apply(V(1, 0, 1, 0, 0, 0, 'h700, 0), "b6");
    apply(V(0, 1, 0, 0, 1, 1, 0, 0), "b7");
    apply(V(0, 1, 0, 0, 0, 0, 0, 0), "b8");
`endif

    chk("sb_drained", 130'(sbq.size()), 130'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
